// File: rtl/apb_sqrt_pkg.sv
// rtl/apb_sqrt_pkg.sv - shared constants, register map and state type for apb_sqrt_slave
package apb_sqrt_pkg;

  localparam int DATA_W = 32;
  localparam int ROOT_W = DATA_W / 2;
  localparam int REM_W  = ROOT_W + 2;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] LAST_ITER = 4'd15;

  // Word indices decoded from PADDR[3:2]
  localparam logic [1:0] REG_OPERAND = 2'd0;
  localparam logic [1:0] REG_RESULT  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_IRQ_EN  = 2'd3;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

endpackage

// File: rtl/sqrt_iter_core.sv
// rtl/sqrt_iter_core.sv - restoring square-root datapath, one root bit per clock
module sqrt_iter_core
  import apb_sqrt_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ROOT_W-1:0] root_o
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] op_q;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [ROOT_W-1:0] acc_q, acc_d;
  logic [ROOT_W-1:0] root_q;
  logic [REM_W+1:0]  rem_sh, trial;
  logic              fits;

  // Bring down the next operand bit pair and try subtracting 4*acc+1
  always_comb begin
    rem_sh = {rem_q, op_q[DATA_W-1 -: 2]};
    trial  = {2'b00, acc_q, 2'b01};
    fits   = (rem_sh >= trial);
    rem_d  = fits ? REM_W'(rem_sh - trial) : rem_sh[REM_W-1:0];
    acc_d  = {acc_q[ROOT_W-2:0], fits};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      root_q  <= '0;
    end else if (load_i) begin
      state_q <= ST_CALC;
      cnt_q   <= '0;
      op_q    <= operand_i;
      rem_q   <= '0;
      acc_q   <= '0;
    end else if (state_q == ST_CALC) begin
      op_q  <= {op_q[DATA_W-3:0], 2'b00};
      rem_q <= rem_d;
      acc_q <= acc_d;
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == LAST_ITER) begin
        state_q <= ST_IDLE;
        root_q  <= acc_d;
      end
    end
  end

  assign busy_o = (state_q == ST_CALC);
  assign done_o = (state_q == ST_CALC) && (cnt_q == LAST_ITER);
  assign root_o = root_q;

endmodule

// File: rtl/apb_sqrt_slave.sv
// rtl/apb_sqrt_slave.sv - APB square-root responder; IRQ port and 0xC register under SQRT_IRQ_EN
module apb_sqrt_slave
  import apb_sqrt_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY
`ifdef SQRT_IRQ_EN
  ,
  output logic              IRQ
`endif
);

  logic              access, busy, stall, xfer;
  logic              wr_operand, rd_result, calc_done;
  logic [1:0]        addr_idx;
  logic [DATA_W-1:0] operand_q;
  logic              done_q, done_d;
  logic              irq_en;
  logic [ROOT_W-1:0] root;
  logic              unused_addr_bits;

  assign addr_idx         = PADDR[3:2];
  assign unused_addr_bits = ^{PADDR[DATA_W-1:4], PADDR[1:0]};
  assign access           = PSEL & PENABLE;

  // Operand writes and result reads wait out an in-flight computation
  assign stall  = access & busy &
                  ((PWRITE & (addr_idx == REG_OPERAND)) | (~PWRITE & (addr_idx == REG_RESULT)));
  assign PREADY = access & ~stall;
  assign xfer   = access & PREADY;

  assign wr_operand = xfer & PWRITE & (addr_idx == REG_OPERAND);
  assign rd_result  = xfer & ~PWRITE & (addr_idx == REG_RESULT);

  sqrt_iter_core u_core (
    .clk_i     (PCLK),
    .rst_ni    (PRESET),
    .load_i    (wr_operand),
    .operand_i (PWDATA),
    .busy_o    (busy),
    .done_o    (calc_done),
    .root_o    (root)
  );

  always_comb begin
    done_d = done_q;
    if (calc_done) begin
      done_d = 1'b1;
    end else if (wr_operand || rd_result) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      operand_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      if (wr_operand) begin
        operand_q <= PWDATA;
      end
    end
  end

`ifdef SQRT_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;

  assign irq_en_d = (xfer & PWRITE & (addr_idx == REG_IRQ_EN)) ? PWDATA[0] : irq_en_q;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_d & irq_en_d;
    end
  end

  assign irq_en = irq_en_q;
  assign IRQ    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    PRDATA = '0;
    if (access) begin
      case (addr_idx)
        REG_OPERAND: PRDATA = operand_q;
        REG_RESULT:  PRDATA = {{(DATA_W-ROOT_W){1'b0}}, root};
        REG_STATUS: begin
          PRDATA[STAT_BUSY]   = busy;
          PRDATA[STAT_DONE]   = done_q;
          PRDATA[STAT_IRQ_EN] = irq_en;
        end
        REG_IRQ_EN:  PRDATA[0] = irq_en;
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_sqrt_slave.sv
// tb/tb_apb_sqrt_slave.sv - self-checking bench for apb_sqrt_slave (optional SQRT_IRQ_EN)
module tb_apb_sqrt_slave;

  localparam int TIMEOUT = 100;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
`ifdef SQRT_IRQ_EN
  logic        IRQ;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  apb_sqrt_slave dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
`ifdef SQRT_IRQ_EN
    ,
    .IRQ     (IRQ)
`endif
  );

  always #5 PCLK = ~PCLK;

  // Largest r with r*r <= x, found by bisection
  function automatic logic [31:0] isqrt_ref(input logic [31:0] x);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid;
    end
    return 32'(lo);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int waits);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    rdata = '0;
    forever begin
      @(negedge PCLK);
      if (PREADY) begin
        rdata = PRDATA;
        break;
      end
      waits++;
      if (waits > TIMEOUT) begin
        n_cmp++;
        n_bad++;
        $display("FAIL apb_timeout: addr 0x%0h still not ready after %0d cycles", addr, waits);
        break;
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output int waits);
    logic [31:0] dummy;
    apb_xfer(1'b1, addr, data, dummy, waits);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output int waits);
    apb_xfer(1'b0, addr, 32'h0, data, waits);
  endtask

  typedef struct {
    logic [31:0] op;
    logic [31:0] root;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] d, op;
  int          w, n;

  initial begin
    vecs[0]  = '{32'd0,        32'd0};
    vecs[1]  = '{32'd1,        32'd1};
    vecs[2]  = '{32'd2,        32'd1};
    vecs[3]  = '{32'd3,        32'd1};
    vecs[4]  = '{32'd4,        32'd2};
    vecs[5]  = '{32'd15,       32'd3};
    vecs[6]  = '{32'd16,       32'd4};
    vecs[7]  = '{32'd17,       32'd4};
    vecs[8]  = '{32'd99,       32'd9};
    vecs[9]  = '{32'd1000000,  32'd1000};
    vecs[10] = '{32'h3FFFFFFF, 32'd32767};
    vecs[11] = '{32'h80000000, 32'd46340};
    vecs[12] = '{32'hFFFE0000, 32'd65534};
    vecs[13] = '{32'hFFFFFFFF, 32'd65535};

    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (2) @(negedge PCLK);
    check("reset_pready", {31'b0, PREADY}, 32'd0);
    check("reset_prdata", PRDATA, 32'd0);
`ifdef SQRT_IRQ_EN
    check("reset_irq", {31'b0, IRQ}, 32'd0);
`endif
    @(posedge PCLK); #1 PRESET = 1'b1;

    // Zero operand, read well after completion: no wait states
    apb_write(32'h0, 32'd0, w);
    check("op0_write_waits", w, 0);
    repeat (17) @(posedge PCLK);
    apb_read(32'h8, d, w);
    check("op0_status_done", d, 32'h2);
    apb_read(32'h4, d, w);
    check("op0_result", d, 32'd0);
    check("op0_result_waits", w, 0);
    apb_read(32'h8, d, w);
    check("op0_status_cleared", d, 32'h0);

    // Immediate result read stalls until the completion edge
    apb_write(32'h0, 32'd144, w);
    apb_read(32'h4, d, w);
    check("op144_result", d, 32'd12);
    check("op144_stall_cycles", w, 14);
    apb_read(32'h8, d, w);
    check("op144_status", d, 32'h0);
    apb_read(32'h0, d, w);
    check("op144_operand", d, 32'd144);
    check("op144_operand_waits", w, 0);

    // Status reads never stall, even mid-computation
    apb_write(32'h0, 32'd17, w);
    apb_read(32'h8, d, w);
    check("busy_status", d, 32'h1);
    check("busy_status_waits", w, 0);
    apb_read(32'h4, d, w);
    check("op17_result", d, 32'd4);

    // Second operand write is held off until the first finishes
    apb_write(32'h0, 32'd100, w);
    apb_write(32'h0, 32'd49, w);
    check("rewrite_stall_cycles", w, 14);
    apb_read(32'h4, d, w);
    check("rewrite_result", d, 32'd7);
    apb_read(32'h0, d, w);
    check("rewrite_operand", d, 32'd49);

`ifndef SQRT_IRQ_EN
    apb_write(32'hC, 32'd1, w);
    check("unmapped_write_waits", w, 0);
    apb_read(32'hC, d, w);
    check("unmapped_read", d, 32'd0);
    apb_read(32'h8, d, w);
    check("unmapped_status", d, 32'h0);
`endif

    // Reset mid-computation aborts and clears everything
    apb_write(32'h0, 32'd1000000, w);
    repeat (7) @(posedge PCLK);
    #2 PRESET = 1'b0;
    #1;
    check("midreset_pready", {31'b0, PREADY}, 32'd0);
    check("midreset_prdata", PRDATA, 32'd0);
    @(posedge PCLK); #1 PRESET = 1'b1;
    apb_read(32'h8, d, w);
    check("midreset_status", d, 32'h0);
    apb_read(32'h4, d, w);
    check("midreset_result", d, 32'd0);
    check("midreset_result_waits", w, 0);
    apb_read(32'h0, d, w);
    check("midreset_operand", d, 32'd0);

    foreach (vecs[i]) begin
      apb_write(32'h0, vecs[i].op, w);
      apb_read(32'h4, d, w);
      check($sformatf("vec%0d_result", i), d, vecs[i].root);
    end

    for (int i = 0; i < 16; i++) begin
      op = $urandom;
      if (i % 4 == 0) op = op >> $urandom_range(0, 30);
      apb_write(32'h0, op, w);
      repeat ($urandom_range(0, 20)) @(posedge PCLK);
      apb_read(32'h4, d, w);
      check($sformatf("rand%0d_result(op=0x%0h)", i, op), d, isqrt_ref(op));
    end

`ifdef SQRT_IRQ_EN
    apb_write(32'hC, 32'd1, w);
    apb_read(32'hC, d, w);
    check("irq_en_readback", d, 32'd1);
    apb_write(32'h0, 32'd81, w);
    n = 0;
    while (!IRQ && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    check("irq_rise", {31'b0, IRQ}, 32'd1);
    check("irq_latency", n, 17);
    apb_read(32'h4, d, w);
    check("irq_result", d, 32'd9);
    @(negedge PCLK);
    check("irq_cleared", {31'b0, IRQ}, 32'd0);
    apb_read(32'h8, d, w);
    check("irq_status", d, 32'h4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_sqrt_slave.md
# apb_sqrt_slave

APB responder peripheral that computes the integer square root of a 32-bit operand written over the bus, one result bit per clock. It sits on the same APB segment as the existing APB master and tangent slave and answers that master's setup/access transfers. Reads of the result while a computation is in flight are held off with PREADY wait states rather than returning stale data.

## Interface
- DATA_W, 32, operand and bus data width
- ROOT_W, 16, result width (DATA_W/2)
- PCLK  in  1  bus clock, all state on rising edge
- PRESET  in  1  asynchronous, active-low reset
- PSEL  in  1  peripheral select
- PENABLE  in  1  access-phase qualifier
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address, bits [3:2] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer completion
- IRQ  out  1  completion interrupt (only with SQRT_IRQ_EN)

## Operation
- Register map:
  - 0x0 OPERAND: W starts computation; R returns last operand.
  - 0x4 RESULT: R returns {16'b0, root}; reading clears DONE.
  - 0x8 STATUS: R = {29'b0, irq_en, DONE, BUSY}.
  - 0xC IRQ_EN: bit0 R/W (macro only).
- Unmapped address: read 0, write ignored, no wait state.
- FSM states IDLE, CALC. IDLE->CALC on accepted OPERAND write. CALC->IDLE when iteration counter reaches 15.
- Algorithm: restoring digit-by-digit, two operand bits per iteration, 18-bit remainder, 16 iterations; result = floor(sqrt(operand)).
- OPERAND write while BUSY: PREADY held low until IDLE, then accepted (new computation starts).
- RESULT read while BUSY: PREADY held low until completion edge; returns new root.
- STATUS/OPERAND reads never stall.
- Reset (any time, including mid-CALC): state IDLE, counter 0, root 0, operand 0, DONE 0, irq_en 0; computation aborted.

## Timing
- Setup phase: PSEL=1, PENABLE=0, one cycle. Access phase: PSEL=1, PENABLE=1 until PREADY=1.
- PREADY combinational: 1 in access phase unless a stall rule applies; 0 outside access phase.
- PRDATA combinational from registers in access phase, 0 otherwise.
- OPERAND accepted at edge E0 -> BUSY=1 from E0 through E16; root and DONE=1 registered at E16. Latency 16 cycles.
- Stalled RESULT read completes in the cycle after E16.
- Reset values: PRDATA 0, PREADY 0, IRQ 0.

## Configuration
- SQRT_IRQ_EN defined: IRQ port and 0xC register exist; IRQ = DONE & irq_en, registered, cleared by RESULT read or reset.
- Undefined: no IRQ port, 0xC treated as unmapped, STATUS bit2 reads 0.

## Structure
- apb_sqrt_pkg: register offsets, state enum, DATA_W/ROOT_W constants, STATUS bit positions.
- Sub-module sqrt_iter_core: load/step/count datapath with done pulse; apb_sqrt_slave holds APB decode, registers, stall logic.

## Test plan
- Write 0 to 0x0, wait 17 cycles, read 0x4 -> 0, no wait states.
- Write 144, immediately read 0x4 -> PREADY low ~15 cycles, PRDATA 12, STATUS afterwards DONE=0.
- Write 0xFFFFFFFF -> RESULT 65535; write 17 -> RESULT 4 (floor).
- Write 100, then write 49 while BUSY -> second write stalls until IDLE, final RESULT 7.
- Write 1000000, assert PRESET at cycle 8 -> STATUS 0, RESULT 0, OPERAND 0.
- With SQRT_IRQ_EN: write 1 to 0xC, write 81 -> IRQ rises after completion; read 0x4 returns 9 and IRQ drops next cycle.
